// File: rtl/read_channel_distributor_pkg.sv
// ============================================================================
// Module   : read_channel_distributor_pkg
// Brief    : Shared FSM encoding and default widths for the read distributor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package read_channel_distributor_pkg;

    // Defaults kept identical to the write-path arbiter so both sides line up.
    localparam int c_num_of_ports       = 16;
    localparam int c_arbiter_data_width = 64;
    localparam int c_des_port_width     = 4;
    localparam int c_cnt_width          = 16;
    localparam int c_timeout_cycles     = 256;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOCK    = 3'd1,
        ST_STREAM  = 3'd2,
        ST_DISCARD = 3'd3,
        ST_DRAIN   = 3'd4
    } dist_state_t;

endpackage

`default_nettype wire

// File: rtl/read_channel_distributor_if.sv
// ============================================================================
// Module   : read_channel_distributor_if
// Brief    : Read-stream input and per-port output bundle of the distributor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface read_channel_distributor_if
    import read_channel_distributor_pkg::*;
#(
    parameter int NUM_OF_PORTS       = c_num_of_ports,
    parameter int ARBITER_DATA_WIDTH = c_arbiter_data_width,
    parameter int DES_PORT_WIDTH     = c_des_port_width,
    parameter int CNT_WIDTH          = c_cnt_width
);
    logic                                       enable;
    logic [DES_PORT_WIDTH-1:0]                  des_port_in;
    logic [ARBITER_DATA_WIDTH-1:0]              data_in;
    logic                                       data_valid;
    logic                                       ready_out;
    logic [ARBITER_DATA_WIDTH*NUM_OF_PORTS-1:0] port_data_out;
    logic [NUM_OF_PORTS-1:0]                    port_valid_out;
    logic [NUM_OF_PORTS-1:0]                    port_ready_in;
    logic [DES_PORT_WIDTH-1:0]                  active_port;
    logic [CNT_WIDTH-1:0]                       beat_count;
    logic                                       frame_done;
    logic                                       port_err;

    modport master (
        output enable, des_port_in, data_in, data_valid, port_ready_in,
        input  ready_out, port_data_out, port_valid_out, active_port,
               beat_count, frame_done, port_err
    );

    modport slave (
        input  enable, des_port_in, data_in, data_valid, port_ready_in,
        output ready_out, port_data_out, port_valid_out, active_port,
               beat_count, frame_done, port_err
    );

endinterface

`default_nettype wire

// File: rtl/read_channel_distributor_port_out_reg.sv
// ============================================================================
// Module   : read_channel_distributor_port_out_reg
// Brief    : One-entry valid/ready holding register with pass-through ready.
//            Stall watchdog compiled in with `define PORT_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module read_channel_distributor_port_out_reg #(
    parameter int DATA_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  load,
    input  wire logic [DATA_WIDTH-1:0] load_data,
    input  wire logic                  port_ready,
    output logic                       out_vld,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       in_ready,
    output logic                       timeout
);
    logic                  r_vld;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  w_timeout;

    if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
        $error("TIMEOUT_CYCLES must be at least 2");
    end

`ifdef PORT_TIMEOUT_EN
    localparam int c_stall_w = $clog2(TIMEOUT_CYCLES);

    logic [c_stall_w-1:0] r_stall_cnt;
    logic                 w_stall;

    assign w_stall   = r_vld & ~port_ready;
    assign w_timeout = w_stall && (r_stall_cnt == c_stall_w'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || !w_stall || w_timeout) begin
            r_stall_cnt <= '0;
        end else begin
            r_stall_cnt <= r_stall_cnt + c_stall_w'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Ready passes straight through so a full register still moves one beat/cycle.
    assign in_ready = ~r_vld | port_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld  <= 1'b0;
            r_data <= '0;
        end else if (load) begin
            r_vld  <= 1'b1;
            r_data <= load_data;
        end else if (port_ready || w_timeout) begin
            r_vld  <= 1'b0;
        end
    end

    assign out_vld  = r_vld;
    assign out_data = r_data;
    assign timeout  = w_timeout;

endmodule

`default_nettype wire

// File: rtl/read_channel_distributor.sv
// ============================================================================
// Module   : read_channel_distributor
// Brief    : Steers each SRAM read frame to one locked output port through a
//            one-entry output register. Optional: `define PORT_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module read_channel_distributor
    import read_channel_distributor_pkg::*;
#(
    parameter int NUM_OF_PORTS       = c_num_of_ports,
    parameter int ARBITER_DATA_WIDTH = c_arbiter_data_width,
    parameter int DES_PORT_WIDTH     = c_des_port_width,
    parameter int CNT_WIDTH          = c_cnt_width,
    parameter int TIMEOUT_CYCLES     = c_timeout_cycles
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    read_channel_distributor_if.slave bus
);
    dist_state_t                   r_state;
    logic [DES_PORT_WIDTH-1:0]     r_active_port;
    logic [CNT_WIDTH-1:0]          r_beat_count;
    logic                          r_port_err;

    logic [NUM_OF_PORTS-1:0]       w_port_sel;
    logic                          w_in_range;
    logic                          w_sel_ready;
    logic                          w_out_vld;
    logic [ARBITER_DATA_WIDTH-1:0] w_out_data;
    logic                          w_in_ready;
    logic                          w_ready_out;
    logic                          w_load;
    logic                          w_timeout;
    logic                          w_out_hs;

    assign w_in_range  = (32'(r_active_port) < NUM_OF_PORTS);
    assign w_sel_ready = |(bus.port_ready_in & w_port_sel);
    assign w_out_hs    = w_out_vld & w_sel_ready;

    for (genvar i = 0; i < NUM_OF_PORTS; i++) begin : g_lane
        assign w_port_sel[i]         = (r_active_port == DES_PORT_WIDTH'(i));
        assign bus.port_valid_out[i] = w_port_sel[i] & w_out_vld;
        assign bus.port_data_out[i*ARBITER_DATA_WIDTH +: ARBITER_DATA_WIDTH] =
            (w_port_sel[i] & w_out_vld) ? w_out_data : '0;
    end

    // The beat offered on the enable-fall cycle is deliberately refused.
    always_comb begin
        w_ready_out = 1'b0;
        unique case (r_state)
            ST_STREAM:  w_ready_out = bus.enable & w_in_ready;
            ST_DISCARD: w_ready_out = 1'b1;
            default:    w_ready_out = 1'b0;
        endcase
    end

    assign w_load = (r_state == ST_STREAM) & bus.data_valid & w_ready_out;

    read_channel_distributor_port_out_reg #(
        .DATA_WIDTH     (ARBITER_DATA_WIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_port_out_reg (
        .clk        (clk),
        .rst        (rst),
        .load       (w_load),
        .load_data  (bus.data_in),
        .port_ready (w_sel_ready),
        .out_vld    (w_out_vld),
        .out_data   (w_out_data),
        .in_ready   (w_in_ready),
        .timeout    (w_timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_active_port <= '0;
            r_beat_count  <= '0;
            r_port_err    <= 1'b0;
        end else begin
            if (w_out_hs && (r_beat_count != '1)) begin
                r_beat_count <= r_beat_count + CNT_WIDTH'(1);
            end
            if (w_timeout) begin
                r_port_err <= 1'b1;
            end
            unique case (r_state)
                ST_IDLE: begin
                    if (bus.enable) begin
                        r_active_port <= bus.des_port_in;
                        r_beat_count  <= '0;
                        r_state       <= ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    if (!w_in_range) begin
                        r_port_err <= 1'b1;
                        r_state    <= bus.enable ? ST_DISCARD : ST_DRAIN;
                    end else begin
                        r_state    <= bus.enable ? ST_STREAM : ST_DRAIN;
                    end
                end
                ST_STREAM: begin
                    if (w_timeout) begin
                        r_state <= ST_DISCARD;
                    end else if (!bus.enable) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DISCARD: begin
                    if (!bus.enable) begin
                        r_active_port <= '0;
                        r_state       <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (!w_out_vld) begin
                        r_active_port <= '0;
                        r_state       <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // frame_done is the single cycle spent leaving DRAIN or DISCARD.
    assign bus.frame_done  = ((r_state == ST_DRAIN) & ~w_out_vld) |
                             ((r_state == ST_DISCARD) & ~bus.enable);
    assign bus.ready_out   = w_ready_out;
    assign bus.active_port = r_active_port;
    assign bus.beat_count  = r_beat_count;
    assign bus.port_err    = r_port_err;

endmodule

`default_nettype wire

// File: tb/tb_read_channel_distributor.sv
// ============================================================================
// Module   : tb_read_channel_distributor
// Brief    : Randomised frame bench with a count-based scoreboard per frame.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_read_channel_distributor;
    localparam int NP = 12;
    localparam int W  = 32;
    localparam int PW = 4;
    localparam int CW = 16;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic exp_err = 1'b0;

    always #5 clk = ~clk;

    read_channel_distributor_if #(
        .NUM_OF_PORTS(NP), .ARBITER_DATA_WIDTH(W), .DES_PORT_WIDTH(PW), .CNT_WIDTH(CW)
    ) bus ();

    read_channel_distributor #(
        .NUM_OF_PORTS(NP), .ARBITER_DATA_WIDTH(W), .DES_PORT_WIDTH(PW),
        .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [NP-1:0] gen_rdy(input int mode, input int cyc, input int port);
        logic [NP-1:0] r;
        r = NP'($urandom);
        if (mode == 0) r = '1;
        else if (mode == 1) r[port] = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        return r;
    endfunction

    // Scoreboard: register occupancy = beats accepted - beats delivered.
    task automatic run_frame(input int port, input int nbeats, input int base,
                             input int gap_pct, input int rdy_mode, input int alt_port);
        logic [W-1:0]  beats[$];
        logic [NP-1:0] rdy;
        logic [NP-1:0] exp_vld;
        logic          exp_ready;
        int sent, deliv, cyc, occ;
        bit done;
        for (int i = 0; i < nbeats; i++) beats.push_back((base >= 0) ? W'(base + i) : W'($urandom));
        @(negedge clk);
        bus.enable = 1'b1; bus.des_port_in = PW'(port); bus.data_valid = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (bus.ready_out !== 1'b0 || bus.active_port !== PW'(port) || bus.beat_count !== '0) begin
            errors++;
            $display("FAIL lock: ready=%b port=%0d cnt=%0d, expected ready=0 port=%0d cnt=0",
                     bus.ready_out, bus.active_port, bus.beat_count, port);
        end
        sent = 0; deliv = 0; cyc = 0; done = 0;
        while (!done) begin
            @(negedge clk);
            occ = sent - deliv;
            bus.enable     = (sent < nbeats);
            bus.data_valid = (sent < nbeats) && ($urandom_range(99) >= gap_pct);
            bus.data_in    = (sent < nbeats) ? beats[sent] : W'($urandom);
            if (alt_port >= 0) bus.des_port_in = PW'(alt_port);
            rdy = gen_rdy(rdy_mode, cyc, port);
            bus.port_ready_in = rdy;
            #1;
            exp_vld = (occ != 0) ? (NP'(1) << port) : '0;
            checks++;
            if (bus.port_valid_out !== exp_vld) begin
                errors++;
                $display("FAIL stream_valid: got %b expected %b", bus.port_valid_out, exp_vld);
            end
            if (occ != 0) begin
                checks++;
                if (bus.port_data_out[port*W +: W] !== beats[deliv]) begin
                    errors++;
                    $display("FAIL stream_data: got %h expected %h", bus.port_data_out[port*W +: W], beats[deliv]);
                end
            end
            exp_ready = bus.enable && ((occ == 0) || rdy[port]);
            checks++;
            if (bus.ready_out !== exp_ready) begin
                errors++;
                $display("FAIL stream_ready: got %b expected %b", bus.ready_out, exp_ready);
            end
            checks++;
            if (bus.active_port !== PW'(port) || bus.beat_count !== CW'(deliv) ||
                bus.frame_done !== 1'b0 || bus.port_err !== exp_err) begin
                errors++;
                $display("FAIL stream_status: port=%0d cnt=%0d done=%b err=%b expected port=%0d cnt=%0d done=0 err=%b",
                         bus.active_port, bus.beat_count, bus.frame_done, bus.port_err, port, deliv, exp_err);
            end
            if (!bus.enable) done = 1;
            if (occ != 0 && rdy[port]) deliv++;
            if (bus.data_valid && bus.ready_out) sent++;
            cyc++;
            if (cyc > 500) begin
                errors++;
                $display("FAIL stream_budget: frame not finished after %0d cycles, expected <= 500", cyc);
                done = 1;
            end
        end
        done = 0; cyc = 0;
        while (!done) begin
            @(negedge clk);
            occ = sent - deliv;
            rdy = gen_rdy(rdy_mode, cyc, port);
            bus.port_ready_in = rdy;
            #1;
            exp_vld = (occ != 0) ? (NP'(1) << port) : '0;
            checks++;
            if (bus.port_valid_out !== exp_vld || bus.ready_out !== 1'b0 || bus.frame_done !== (occ == 0)) begin
                errors++;
                $display("FAIL drain: vld=%b ready=%b done=%b expected vld=%b ready=0 done=%b",
                         bus.port_valid_out, bus.ready_out, bus.frame_done, exp_vld, (occ == 0));
            end
            if (occ != 0) begin
                checks++;
                if (bus.port_data_out[port*W +: W] !== beats[deliv]) begin
                    errors++;
                    $display("FAIL drain_data: got %h expected %h", bus.port_data_out[port*W +: W], beats[deliv]);
                end
            end
            if (occ == 0) done = 1;
            if (occ != 0 && rdy[port]) deliv++;
            cyc++;
            if (cyc > 500) begin
                errors++;
                $display("FAIL drain_budget: no frame_done after %0d cycles, expected <= 500", cyc);
                done = 1;
            end
        end
        @(negedge clk); #1;
        checks++;
        if (bus.active_port !== '0 || bus.beat_count !== CW'(nbeats) ||
            bus.frame_done !== 1'b0 || bus.port_valid_out !== '0) begin
            errors++;
            $display("FAIL idle_after_frame: port=%0d cnt=%0d done=%b vld=%b expected 0 %0d 0 0",
                     bus.active_port, bus.beat_count, bus.frame_done, bus.port_valid_out, nbeats);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.enable = 1'b0; bus.des_port_in = '0; bus.data_in = '0;
        bus.data_valid = 1'b0; bus.port_ready_in = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (bus.ready_out !== 1'b0 || bus.port_valid_out !== '0 || bus.port_data_out !== '0 ||
            bus.active_port !== '0 || bus.beat_count !== '0 || bus.frame_done !== 1'b0 || bus.port_err !== 1'b0) begin
            errors++;
            $display("FAIL reset: ready=%b vld=%b port=%0d cnt=%0d done=%b err=%b expected all 0",
                     bus.ready_out, bus.port_valid_out, bus.active_port, bus.beat_count, bus.frame_done, bus.port_err);
        end
        rst = 1'b0;
        exp_err = 1'b0;
    endtask

    task automatic test_basic();
        run_frame(5, 4, 'hA0, 0, 0, -1);
    endtask

    task automatic test_backpressure();
        run_frame(3, 6, -1, 0, 1, -1);
    endtask

    task automatic test_port_lock();
        run_frame(2, 6, -1, 10, 2, 7);
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 6; f++) run_frame($urandom_range(NP - 1), $urandom_range(12, 1), -1, 30, 2, -1);
    endtask

    task automatic test_lock_drop();
        @(negedge clk); bus.enable = 1'b1; bus.des_port_in = PW'(9);
        @(negedge clk); bus.enable = 1'b0; #1;
        checks++;
        if (bus.ready_out !== 1'b0 || bus.frame_done !== 1'b0) begin
            errors++;
            $display("FAIL lock_drop_lock: ready=%b done=%b expected 0 0", bus.ready_out, bus.frame_done);
        end
        @(negedge clk); #1;
        checks++;
        if (bus.frame_done !== 1'b1 || bus.beat_count !== '0 || bus.port_valid_out !== '0) begin
            errors++;
            $display("FAIL lock_drop_done: done=%b cnt=%0d vld=%b expected 1 0 0", bus.frame_done, bus.beat_count, bus.port_valid_out);
        end
        @(negedge clk); #1;
        checks++;
        if (bus.frame_done !== 1'b0 || bus.active_port !== '0) begin
            errors++;
            $display("FAIL lock_drop_idle: done=%b port=%0d expected 0 0", bus.frame_done, bus.active_port);
        end
    endtask

    task automatic test_out_of_range();
        @(negedge clk); bus.enable = 1'b1; bus.des_port_in = PW'(13); bus.data_valid = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (bus.ready_out !== 1'b0) begin
            errors++;
            $display("FAIL oor_lock: ready=%b expected 0", bus.ready_out);
        end
        exp_err = 1'b1;
        repeat (6) begin
            @(negedge clk);
            bus.data_valid = 1'($urandom); bus.data_in = W'($urandom); bus.port_ready_in = NP'($urandom);
            #1;
            checks++;
            if (bus.ready_out !== 1'b1 || bus.port_valid_out !== '0 || bus.port_err !== 1'b1 ||
                bus.frame_done !== 1'b0 || bus.beat_count !== '0) begin
                errors++;
                $display("FAIL oor_discard: ready=%b vld=%b err=%b done=%b cnt=%0d expected 1 0 1 0 0",
                         bus.ready_out, bus.port_valid_out, bus.port_err, bus.frame_done, bus.beat_count);
            end
        end
        @(negedge clk); bus.enable = 1'b0; bus.data_valid = 1'b0; #1;
        checks++;
        if (bus.frame_done !== 1'b1) begin
            errors++;
            $display("FAIL oor_done: done=%b expected 1", bus.frame_done);
        end
        @(negedge clk); #1;
        checks++;
        if (bus.frame_done !== 1'b0 || bus.active_port !== '0 || bus.port_err !== 1'b1) begin
            errors++;
            $display("FAIL oor_idle: done=%b port=%0d err=%b expected 0 0 1", bus.frame_done, bus.active_port, bus.port_err);
        end
    endtask

    task automatic test_reset_mid_frame();
        @(negedge clk); bus.enable = 1'b1; bus.des_port_in = PW'(4); bus.port_ready_in = '0; bus.data_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); bus.data_valid = 1'b1; bus.data_in = W'($urandom);
        @(negedge clk); bus.data_valid = 1'b0; #1;
        checks++;
        if (bus.port_valid_out !== (NP'(1) << 4)) begin
            errors++;
            $display("FAIL rst_mid_full: vld=%b expected %b", bus.port_valid_out, NP'(1) << 4);
        end
        rst = 1'b1;
        @(negedge clk); rst = 1'b0; bus.enable = 1'b0; exp_err = 1'b0; #1;
        checks++;
        if (bus.ready_out !== 1'b0 || bus.port_valid_out !== '0 || bus.port_data_out !== '0 ||
            bus.active_port !== '0 || bus.beat_count !== '0 || bus.frame_done !== 1'b0 || bus.port_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_clear: ready=%b vld=%b port=%0d cnt=%0d done=%b err=%b expected all 0",
                     bus.ready_out, bus.port_valid_out, bus.active_port, bus.beat_count, bus.frame_done, bus.port_err);
        end
        @(negedge clk); #1;
        checks++;
        if (bus.frame_done !== 1'b0 || bus.port_valid_out !== '0) begin
            errors++;
            $display("FAIL rst_mid_quiet: done=%b vld=%b expected 0 0", bus.frame_done, bus.port_valid_out);
        end
        run_frame(6, 5, -1, 20, 2, -1);
    endtask

`ifdef PORT_TIMEOUT_EN
    task automatic test_timeout();
        @(negedge clk); bus.enable = 1'b1; bus.des_port_in = PW'(1); bus.port_ready_in = '0; bus.data_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); bus.data_valid = 1'b1; bus.data_in = W'('h5A5A);
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk); bus.data_valid = 1'b0; #1;
            checks++;
            if (bus.port_valid_out !== NP'(2) || bus.ready_out !== 1'b0) begin
                errors++;
                $display("FAIL timeout_hold cycle %0d: vld=%b ready=%b expected %b 0", k, bus.port_valid_out, bus.ready_out, NP'(2));
            end
        end
        @(negedge clk); #1;
        exp_err = 1'b1;
        checks++;
        if (bus.port_valid_out !== '0 || bus.port_err !== 1'b1 || bus.ready_out !== 1'b1) begin
            errors++;
            $display("FAIL timeout_drop: vld=%b err=%b ready=%b expected 0 1 1", bus.port_valid_out, bus.port_err, bus.ready_out);
        end
        @(negedge clk); bus.enable = 1'b0; #1;
        checks++;
        if (bus.frame_done !== 1'b1 || bus.beat_count !== '0) begin
            errors++;
            $display("FAIL timeout_done: done=%b cnt=%0d expected 1 0", bus.frame_done, bus.beat_count);
        end
        @(negedge clk); #1;
        checks++;
        if (bus.active_port !== '0 || bus.frame_done !== 1'b0) begin
            errors++;
            $display("FAIL timeout_idle: port=%0d done=%b expected 0 0", bus.active_port, bus.frame_done);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_port_lock();
        test_random_frames();
        test_lock_drop();
        test_out_of_range();
        test_reset_mid_frame();
`ifdef PORT_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/read_channel_distributor.md
Name: read_channel_distributor

Overview:
Read-side counterpart of the write-path channel selector. It takes the single read-data stream coming out of the SRAM read path and delivers each frame to one of num_of_ports output channels. The destination port is locked at frame start. Each beat is passed through a one-entry output register with per-port valid/ready backpressure.

Parameters:
num_of_ports, 16, number of output channels
arbiter_data_width, 64, data beat width
des_port_width, 4, destination-port index width
cnt_width, 16, beat-counter width
timeout_cycles, 256, stall limit (used only with optional feature)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
enable  in  1  frame active; high for the whole frame
des_port_in  in  des_port_width  destination port, sampled on the lock cycle only
data_in  in  arbiter_data_width  read beat
data_valid  in  1  data_in valid
ready_out  out  1  beat accepted when data_valid && ready_out
port_data_out  out  arbiter_data_width*num_of_ports  lane i = bits [(i+1)*W-1 : i*W]
port_valid_out  out  num_of_ports  one-hot; at most one bit set
port_ready_in  in  num_of_ports  per-port ready
active_port  out  des_port_width  locked port; 0 when IDLE
beat_count  out  cnt_width  beats delivered in the current/last frame
frame_done  out  1  one-cycle pulse at end of drain
port_err  out  1  sticky: out-of-range port (plus timeout if enabled)

Behaviour:
- Reset is synchronous on clk while rst=1. All outputs are 0, state is IDLE, and the output register is empty. Reset mid-frame discards the in-flight word with no frame_done.
- FSM states:
  - IDLE: ready_out=0. On enable=1, latch des_port_in into active_port, clear beat_count, go to LOCK.
  - LOCK: one setup cycle with ready_out=0. If active_port >= num_of_ports, set port_err and go to DISCARD; otherwise go to STREAM.
  - STREAM: ready_out = ~out_vld | port_ready_in[active_port]. An accepted beat loads the output register in the same cycle it is popped (full throughput, one beat/cycle).
    - When enable=0, go to DRAIN. The beat on that cycle is not accepted.
  - DISCARD: ready_out=1 and beats are dropped; beat_count does not increment. When enable=0, pulse frame_done and go to IDLE.
  - DRAIN: ready_out=0. Once the output register is empty, pulse frame_done and go to IDLE.
- Output register:
  - port_valid_out[active_port] = out_vld.
  - All lanes carry the register contents; lanes that are not valid are don't-care but driven 0.
  - Latency is 1 cycle from acceptance to valid.
- beat_count increments on each output handshake (valid && ready at the port). It saturates at all-ones and holds its value after frame_done until the next LOCK.
- des_port_in changes during a frame are ignored.
- enable is never sampled again during DRAIN. A new frame needs IDLE first, so the minimum inter-frame gap is 1 cycle.
- If enable drops in LOCK, go straight to DRAIN (output register empty): frame_done fires the next cycle with beat_count=0.
- port_ready_in bits for ports other than active_port are ignored.

Optional Feature:
PORT_TIMEOUT_EN
- Defined: a stall counter increments while out_vld=1 and port_ready_in[active_port]=0, and clears on handshake. When it reaches timeout_cycles:
  - the held word is dropped (out_vld <= 0);
  - port_err is set (sticky);
  - the FSM moves to DISCARD if still in STREAM, or completes DRAIN normally.
- Undefined: no counter; a stalled port blocks indefinitely and port_err only reflects out-of-range ports.

Decomposition:
- Shared package: FSM state encoding (IDLE, LOCK, STREAM, DISCARD, DRAIN) and the default width constants shared with the write arbiter.
- One natural sub-module: port_out_reg, the one-entry valid/ready holding register with pass-through ready (and the stall counter when PORT_TIMEOUT_EN is defined).

Test Plan:
- Basic frame: enable high, des_port_in=5, 4 beats 0xA0..0xA3 back-to-back, port_ready_in all 1 -> lane 5 valid in the 4 consecutive cycles after LOCK, data in order; frame_done 1 cycle after the last output; beat_count=4.
- Backpressure: port 3, port_ready_in[3] toggles 1,0,0,1 -> no beat lost or duplicated; ready_out low exactly while the register is full and unready; all other port_valid_out bits stay 0.
- Port lock: des_port_in changes from 2 to 7 mid-frame -> all beats on lane 2; active_port stays 2.
- Out-of-range: num_of_ports=12, des_port_in=13 -> port_err=1, ready_out=1, no port_valid_out asserted, frame_done on enable fall.
- Reset mid-frame: rst asserted with the register full -> next cycle all outputs 0, state IDLE, no frame_done; a following frame works normally.
- With PORT_TIMEOUT_EN and timeout_cycles=8: hold port_ready_in[1]=0 -> word dropped after 8 stalled cycles, port_err=1, frame completes via DISCARD.
